genetico_ctrl: RTL and testbench
================================

GENETICO_CTRL -- requirements
Module: genetico_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have ports: cfg_valid in 1, serial chromosome bit valid; cfg_bit in 1, chromosome bit; cfg_ready out 1, bit accepted when cfg_valid&&cfg_ready.
REQ-003 SHALL have ports: start in 1, evaluation request; busy out 1, evaluation in progress; done out 1, one-cycle completion pulse; loaded out 1, complete chromosome held.
REQ-004 SHALL have ports: conf_les out 405 (27x15, LE k at bits [15k+14:15k]); conf_outs out 24 (4x6, output j at bits [6j+5:6j]); chromIn out 8; chromOut in 4, all to/from the genetic array.
REQ-005 SHALL have ports: target_addr out 8; target_data in 4, combinational truth-table lookup; fitness out 11, match count.

Function
REQ-006 SHALL hold a 429-bit chromosome register chrom; conf_les = chrom[428:24], conf_outs = chrom[23:0], both driven directly from the register.
REQ-007 SHALL shift chrom left one bit per accepted cfg bit, inserting cfg_bit at bit 0; the first accepted bit of a 429-bit load ends at bit 428.
REQ-008 SHALL count accepted bits 0..428; loaded rises the cycle after the 429th accepted bit; counter returns to 0.
REQ-009 SHALL, on an accepted bit while loaded=1, clear loaded and begin a fresh load, that bit counting as bit 1.
REQ-010 SHALL use states IDLE, EVAL, DONE; cfg_ready=1 only in IDLE.
REQ-011 SHALL, in IDLE with start=1 and loaded=1, go to EVAL, clear fitness to 0, set vector index to 0; start ignored in IDLE with loaded=0 and in EVAL/DONE.
REQ-012 SHALL drive chromIn = target_addr = vector index in EVAL, both 0 outside EVAL.
REQ-013 SHALL, in each EVAL compare cycle, add popcount(~(chromOut ^ target_data)) (0..4) to fitness, then increment the index.
REQ-014 SHALL go to DONE after the compare of index 255; DONE lasts one cycle with done=1, then returns to IDLE.
REQ-015 SHALL assert busy in EVAL and DONE only.
REQ-016 SHALL hold fitness stable from DONE until the next accepted start; maximum 1024 (11 bits, no overflow).
REQ-017 SHALL give latency: start accepted at edge 0, done=1 in cycle 257 (default build).
REQ-018 SHALL not alter chrom, loaded or the bit counter while busy; cfg_valid during busy is not accepted.

Reset
REQ-019 SHALL, on rst_n=0 at any time incl. mid-EVAL or mid-load, immediately force: state IDLE, chrom=0, bit counter=0, loaded=0, index=0, fitness=0, busy=0, done=0, chromIn=0, target_addr=0, cfg_ready=0 while rst_n=0.
REQ-020 SHALL assert cfg_ready on the first clk edge after rst_n deasserts.

Configuration
REQ-021 SHALL support macro GENETICO_SETTLE_EN: when defined, each vector is driven for 2 cycles (settle cycle, then compare cycle), only the compare cycle accumulates, done=1 in cycle 513; when undefined, 1 cycle per vector per REQ-013/REQ-017.

Verification
REQ-022 SHALL cover: load chrom with all LEs 0, conf_outs j = j (chromOut=chromIn[3:0]), target_data=target_addr[3:0], start -> done at cycle 257, fitness=1024.
REQ-023 SHALL cover: same chromosome, target_data=~target_addr[3:0] -> fitness=0; then target_data=4'b0000 -> fitness=512.
REQ-024 SHALL cover: start with loaded=0 (428 bits sent) -> busy stays 0, no done, fitness unchanged.
REQ-025 SHALL cover: cfg_valid=1 throughout EVAL -> cfg_ready=0, chrom unchanged, fitness=1024 as in REQ-022.
REQ-026 SHALL cover: rst_n low at EVAL index 100 -> all outputs at REQ-019 values, loaded=0, subsequent start ignored until reload.
REQ-027 SHALL cover: GENETICO_SETTLE_EN defined, REQ-022 stimulus -> done at cycle 513, fitness=1024.

Source files
------------

// File: rtl/genetico_ctrl.sv
// rtl/genetico_ctrl.sv - serial chromosome loader and 256-vector fitness evaluator for a genetic array
// Optional macro GENETICO_SETTLE_EN: drive each vector for a settle cycle before its compare cycle.
module genetico_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_valid,
  input  logic         cfg_bit,
  output logic         cfg_ready,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         loaded,
  output logic [404:0] conf_les,
  output logic [23:0]  conf_outs,
  output logic [7:0]   chromIn,
  input  logic [3:0]   chromOut,
  output logic [7:0]   target_addr,
  input  logic [3:0]   target_data,
  output logic [10:0]  fitness
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t       r_state;
  state_t       w_next;
  logic         r_live;
  logic [428:0] r_chrom;
  logic [8:0]   r_cnt;
  logic         r_loaded;
  logic [7:0]   r_idx;
  logic [10:0]  r_fit;
  logic         w_start_acc;
  logic         w_bit_acc;
  logic         w_cmp;
  logic         w_last;
  logic [3:0]   w_eq;
  logic [2:0]   w_pop;

`ifdef GENETICO_SETTLE_EN
  logic         r_phase;
  assign w_cmp = (r_state == S_EVAL) && r_phase;
`else
  assign w_cmp = (r_state == S_EVAL);
`endif

  // A start accepted in the same cycle as a cfg bit wins, so the chromosome under test stays intact.
  assign w_start_acc = (r_state == S_IDLE) && start && r_loaded;
  assign cfg_ready   = r_live && (r_state == S_IDLE) && !w_start_acc;
  assign w_bit_acc   = cfg_valid && cfg_ready;
  assign w_last      = w_cmp && (r_idx == 8'd255);

  assign w_eq  = ~(chromOut ^ target_data);
  assign w_pop = {2'b00, w_eq[0]} + {2'b00, w_eq[1]} + {2'b00, w_eq[2]} + {2'b00, w_eq[3]};

  assign conf_les    = r_chrom[428:24];
  assign conf_outs   = r_chrom[23:0];
  assign loaded      = r_loaded;
  assign fitness     = r_fit;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign chromIn     = (r_state == S_EVAL) ? r_idx : 8'd0;
  assign target_addr = (r_state == S_EVAL) ? r_idx : 8'd0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_acc) w_next = S_EVAL;
      S_EVAL:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chrom  <= '0;
      r_cnt    <= 9'd0;
      r_loaded <= 1'b0;
    end else if (w_bit_acc) begin
      r_chrom <= {r_chrom[427:0], cfg_bit};
      if (r_loaded) begin
        r_loaded <= 1'b0;
        r_cnt    <= 9'd1;
      end else if (r_cnt == 9'd428) begin
        r_loaded <= 1'b1;
        r_cnt    <= 9'd0;
      end else begin
        r_cnt <= r_cnt + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 8'd0;
      r_fit <= 11'd0;
    end else if (w_start_acc) begin
      r_idx <= 8'd0;
      r_fit <= 11'd0;
    end else if (w_cmp) begin
      r_idx <= r_idx + 8'd1;
      r_fit <= r_fit + {8'd0, w_pop};
    end
  end

`ifdef GENETICO_SETTLE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 1'b0;
    end else if (w_start_acc) begin
      r_phase <= 1'b0;
    end else if (r_state == S_EVAL) begin
      r_phase <= !r_phase;
    end
  end
`endif

endmodule

// File: tb/tb_genetico_ctrl.sv
// tb/tb_genetico_ctrl.sv - self-checking bench for genetico_ctrl with a behavioural genetic-array model
module tb_genetico_ctrl;

`ifdef GENETICO_SETTLE_EN
  localparam int EXP_LAT = 513;
`else
  localparam int EXP_LAT = 257;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_bit = 1'b0;
  logic         cfg_ready;
  logic         start = 1'b0;
  logic         busy, done, loaded;
  logic [404:0] conf_les;
  logic [23:0]  conf_outs;
  logic [7:0]   chromIn;
  logic [3:0]   chromOut;
  logic [7:0]   target_addr;
  logic [3:0]   target_data;
  logic [10:0]  fitness;

  int total = 0;
  int bad = 0;
  int tmode = 0;
  logic [3:0] tbl [256];

  genetico_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_ready(cfg_ready),
    .start(start), .busy(busy), .done(done), .loaded(loaded), .conf_les(conf_les),
    .conf_outs(conf_outs), .chromIn(chromIn), .chromOut(chromOut), .target_addr(target_addr),
    .target_data(target_data), .fitness(fitness)
  );

  always #5 clk = ~clk;

  // Genetic array stand-in: output j follows chromIn bit selected by conf_outs j (sources 8+ read 0).
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      logic [5:0] s;
      s = conf_outs[6*j +: 6];
      chromOut[j] = (s < 6'd8) ? chromIn[s[2:0]] : 1'b0;
    end
  end

  always_comb begin
    case (tmode)
      0:       target_data = target_addr[3:0];
      1:       target_data = ~target_addr[3:0];
      2:       target_data = 4'b0000;
      3:       target_data = 4'b1111;
      default: target_data = tbl[target_addr];
    endcase
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [428:0] mk_chrom(input logic [404:0] les, input int s0, input int s1,
                                            input int s2, input int s3);
    return {les, 6'(s3), 6'(s2), 6'(s1), 6'(s0)};
  endfunction

  function automatic int ref_fit(input int s0, input int s1, input int s2, input int s3);
    int f = 0;
    int sel [4];
    sel = '{s0, s1, s2, s3};
    for (int a = 0; a < 256; a++) begin
      for (int j = 0; j < 4; j++) begin
        int o;
        o = (a >> sel[j]) & 1;
        if (o == int'(tbl[a][j])) f++;
      end
    end
    return f;
  endfunction

  task automatic send_bit(input logic b);
    int g = 0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_bit = b;
    while (!cfg_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) chk("cfg_ready_timeout", g, 0);
    @(posedge clk);
  endtask

  task automatic load(input logic [428:0] v, input int n);
    logic was_loaded;
    was_loaded = loaded;
    for (int i = 0; i < n; i++) begin
      send_bit(v[428 - i]);
      if (i == 0 && was_loaded) begin
        #1;
        chk("reload_clears_loaded", loaded, 0);
      end
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic run_eval(input logic hold_cfg, output int cyc);
    int idle_seen = 0;
    int ready_seen = 0;
    @(negedge clk);
    start = 1'b1;
    if (hold_cfg) begin
      cfg_valid = 1'b1;
      cfg_bit = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 1000) begin
      if (!busy) idle_seen++;
      if (cfg_ready) ready_seen++;
      @(negedge clk);
      cyc++;
    end
    cfg_valid = 1'b0;
    chk("busy_gap", idle_seen, 0);
    if (hold_cfg) chk("cfg_ready_in_eval", ready_seen, 0);
    chk("latency", cyc, EXP_LAT);
  endtask

  typedef struct {
    int mode;
    int fit;
  } vec_t;

  initial begin
    vec_t vt [4];
    logic [428:0] cid;
    logic [404:0] les;
    int cyc, g, bcnt, dcnt;
    int s [4];

    vt[0] = '{0, 1024};
    vt[1] = '{1, 0};
    vt[2] = '{2, 512};
    vt[3] = '{3, 512};
    cid = mk_chrom('0, 0, 1, 2, 3);

    #3;
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_fitness", fitness, 0);
    chk("rst_chrom_zero", ({conf_les, conf_outs} == 429'd0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cfg_ready_after_rst", cfg_ready, 1);

    // 428 bits only: start must be ignored
    load(cid, 428);
    chk("partial_not_loaded", loaded, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcnt = 0;
    dcnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy) bcnt++;
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("unloaded_busy", bcnt, 0);
    chk("unloaded_done", dcnt, 0);
    chk("unloaded_fitness", fitness, 0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load(cid, 429);
    chk("loaded", loaded, 1);
    chk("chrom_identity", ({conf_les, conf_outs} == cid), 1);

    for (int k = 0; k < 4; k++) begin
      tmode = vt[k].mode;
      run_eval(1'b0, cyc);
      chk($sformatf("fitness_mode%0d", k), fitness, vt[k].fit);
      repeat (3) @(negedge clk);
      chk($sformatf("fitness_hold_mode%0d", k), fitness, vt[k].fit);
      chk($sformatf("busy_after_mode%0d", k), busy, 0);
    end

    tmode = 0;
    run_eval(1'b1, cyc);
    chk("hold_cfg_fitness", fitness, 1024);
    chk("hold_cfg_chrom", ({conf_les, conf_outs} == cid), 1);
    chk("hold_cfg_loaded", loaded, 1);

    // reset in the middle of evaluation
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (chromIn != 8'd100 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("reach_index100", chromIn, 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_chromIn", chromIn, 0);
    chk("mid_rst_target_addr", target_addr, 0);
    chk("mid_rst_fitness", fitness, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 0);
    chk("mid_rst_loaded", loaded, 0);
    chk("mid_rst_chrom", ({conf_les, conf_outs} == 429'd0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) bcnt++;
      @(negedge clk);
    end
    chk("post_rst_start_ignored", bcnt, 0);
    load(cid, 429);
    run_eval(1'b0, cyc);
    chk("post_rst_fitness", fitness, 1024);

    // randomized chromosomes and target tables against the reference model
    tmode = 4;
    for (int r = 0; r < 3; r++) begin
      logic [428:0] cr;
      for (int b = 0; b < 405; b++) les[b] = 1'($urandom);
      for (int j = 0; j < 4; j++) s[j] = int'($urandom_range(0, 7));
      for (int a = 0; a < 256; a++) tbl[a] = 4'($urandom);
      cr = mk_chrom(les, s[0], s[1], s[2], s[3]);
      load(cr, 429);
      chk($sformatf("rand_chrom%0d", r), ({conf_les, conf_outs} == cr), 1);
      run_eval(1'b0, cyc);
      chk($sformatf("rand_fitness%0d", r), fitness, ref_fit(s[0], s[1], s[2], s[3]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
